cdc_fifo_wr_arbiter: RTL and testbench

CDC_FIFO_WR_ARBITER -- requirements
Module: cdc_fifo_wr_arbiter

---
 rtl/cdc_pkg.sv | 15 +
 rtl/cdc_rr_picker.sv | 34 +++
 rtl/cdc_fifo_wr_arbiter.sv | 111 +++++++++++
 tb/tb_cdc_fifo_wr_arbiter.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/cdc_pkg.sv
// Shared types and helpers for the CDC FIFO write-side arbiter.
package cdc_pkg;

    // Arbiter FSM states
    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_st_t;

    // Index width for n requesters, never narrower than one bit
    function automatic int idw_f(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/cdc_rr_picker.sv
// Combinational round-robin picker: first set request at or after ptr_i,
// wrapping modulo N_REQ. N_REQ is a power of two, so index wrap is free.
module cdc_rr_picker
    import cdc_pkg::*;
#(
    parameter  int N_REQ = 4,
    localparam int IDW   = idw_f(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDW-1:0]   ptr_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic [IDW-1:0]   idx_o
);

    logic           found;
    logic [IDW-1:0] cand;

    // Scan from the pointer upward and keep the first hit
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        cand  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = ptr_i + IDW'(i);
            if (!found && req_i[cand]) begin
                found        = 1'b1;
                idx_o        = cand;
                gnt_o[cand]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cdc_fifo_wr_arbiter.sv
// Round-robin burst arbiter feeding the write side of an async FIFO.
// An owner is latched in IDLE and streams up to MAX_BURST beats in BURST.
module cdc_fifo_wr_arbiter
    import cdc_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                                 clk_wr,
    input  logic                                 arst_wr,
    input  logic [N_REQ-1:0]                     req_valid_i,
    input  logic [N_REQ-1:0][WIDTH-1:0]          req_data_i,
    input  logic [N_REQ-1:0]                     req_last_i,
    output logic [N_REQ-1:0]                     req_ready_o,
    input  logic                                 fifo_full_i,
    output logic                                 fifo_wr_en_o,
    output logic [idw_f(N_REQ)+WIDTH-1:0]        fifo_wr_data_o,
    output logic [N_REQ-1:0]                     grant_o,
    output logic                                 busy_o
);

    localparam int IDW = idw_f(N_REQ);
    localparam int CW  = $clog2(MAX_BURST + 1);

`ifndef NO_ASSERTIONS
    if ((N_REQ < 2) || ((N_REQ & (N_REQ - 1)) != 0)) begin : g_chk_nreq
        $error("cdc_fifo_wr_arbiter: N_REQ must be a power of 2 and >= 2");
    end
    if (MAX_BURST < 1) begin : g_chk_burst
        $error("cdc_fifo_wr_arbiter: MAX_BURST must be >= 1");
    end
`endif

    arb_st_t        state_q;
    logic [IDW-1:0] owner_q;
    logic [IDW-1:0] rr_ptr_q;
    logic [CW-1:0]  cnt_q;

    logic [N_REQ-1:0] pick_gnt;
    logic [IDW-1:0]   pick_idx;
    logic             any_req;
    logic             busy;
    logic             own_valid;
    logic             own_last;
    logic             xfer;
    logic             burst_done;
    logic [CW-1:0]    cnt_d;

    cdc_rr_picker #(.N_REQ(N_REQ)) u_pick (
        .req_i (req_valid_i),
        .ptr_i (rr_ptr_q),
        .gnt_o (pick_gnt),
        .idx_o (pick_idx)
    );

    assign any_req    = |pick_gnt;
    assign busy       = (state_q == BURST);
    assign own_valid  = req_valid_i[owner_q];
    assign own_last   = req_last_i[owner_q];
    assign xfer       = busy && own_valid && !fifo_full_i;
    assign cnt_d      = cnt_q + CW'(1);
    // Packet end or burst cap; only meaningful on a transfer cycle
    assign burst_done = own_last || (cnt_d == CW'(MAX_BURST));

    // Owner-facing handshake and FIFO write path; all zero outside BURST
    always_comb begin
        req_ready_o          = '0;
        grant_o              = '0;
        req_ready_o[owner_q] = busy && !fifo_full_i;
        grant_o[owner_q]     = busy;
        busy_o               = busy;
        fifo_wr_en_o         = xfer;
        fifo_wr_data_o       = xfer ? {owner_q, req_data_i[owner_q]} : '0;
    end

    // Arbitration FSM: latch owner in IDLE, count beats and exit in BURST
    always_ff @(posedge clk_wr or posedge arst_wr) begin
        if (arst_wr) begin
            state_q  <= IDLE;
            owner_q  <= '0;
            rr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (any_req) begin
                        state_q <= BURST;
                        owner_q <= pick_idx;
                        cnt_q   <= '0;
                    end
                end
                BURST: begin
                    // A transfer wins over abandon; a stall just holds
                    if (xfer) begin
                        cnt_q <= cnt_d;
                        if (burst_done) begin
                            state_q  <= IDLE;
                            rr_ptr_q <= owner_q + IDW'(1);
                        end
                    end else if (!own_valid) begin
                        state_q  <= IDLE;
                        rr_ptr_q <= owner_q + IDW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cdc_fifo_wr_arbiter.sv
// Randomized scoreboard bench for cdc_fifo_wr_arbiter (N_REQ=4, WIDTH=8,
// MAX_BURST=4). The driver runs a behavioural model and queues expected
// per-cycle status and expected FIFO writes; the monitor checks them.
module tb_cdc_fifo_wr_arbiter;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int MB = 4;

    logic                clk_wr = 1'b0;
    logic                arst_wr;
    logic [N-1:0]        req_valid_i;
    logic [N-1:0][W-1:0] req_data_i;
    logic [N-1:0]        req_last_i;
    logic [N-1:0]        req_ready_o;
    logic                fifo_full_i;
    logic                fifo_wr_en_o;
    logic [2+W-1:0]      fifo_wr_data_o;
    logic [N-1:0]        grant_o;
    logic                busy_o;

    cdc_fifo_wr_arbiter #(.N_REQ(N), .WIDTH(W), .MAX_BURST(MB)) dut (
        .clk_wr         (clk_wr),
        .arst_wr        (arst_wr),
        .req_valid_i    (req_valid_i),
        .req_data_i     (req_data_i),
        .req_last_i     (req_last_i),
        .req_ready_o    (req_ready_o),
        .fifo_full_i    (fifo_full_i),
        .fifo_wr_en_o   (fifo_wr_en_o),
        .fifo_wr_data_o (fifo_wr_data_o),
        .grant_o        (grant_o),
        .busy_o         (busy_o)
    );

    always #5 clk_wr = ~clk_wr;

    typedef struct packed {
        logic [N-1:0] gnt;
        logic [N-1:0] rdy;
        logic         busy;
        logic         wen;
    } cyc_t;

    cyc_t          exp_q[$];
    logic [9:0]    wr_q[$];
    int            n_cmp = 0;
    int            n_bad = 0;

    // Reference model: owner (-1 = idle), pointer, beats in this burst
    int            m_own = -1;
    int            m_ptr = 0;
    int            m_beats = 0;
    bit            skip_adv = 1'b1;
    // Requester-side packet state
    int            left[N];
    logic [W-1:0]  pdata[N];
    int            lmin = 1;
    int            lmax = 6;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", name, got, want, $time);
        end
    endtask

    task automatic consume(input int r);
        left[r]--;
        pdata[r] = W'($urandom);
        if (left[r] == 0) left[r] = $urandom_range(lmax, lmin);
    endtask

    // Apply one clock of the arbitration rules to the inputs held last cycle
    task automatic model_advance();
        bit found;
        int c;
        if (m_own < 0) begin
            found = 1'b0;
            for (int i = 0; i < N; i++) begin
                c = (m_ptr + i) % N;
                if (!found && req_valid_i[c]) begin
                    found   = 1'b1;
                    m_own   = c;
                    m_beats = 0;
                end
            end
        end else if (req_valid_i[m_own] && !fifo_full_i) begin
            m_beats++;
            consume(m_own);
            if (req_last_i[m_own] || m_beats == MB) begin
                m_ptr = (m_own + 1) % N;
                m_own = -1;
            end
        end else if (!req_valid_i[m_own]) begin
            m_ptr = (m_own + 1) % N;
            m_own = -1;
        end
    endtask

    task automatic drive(input int pv, input int pf, input logic [N-1:0] mask);
        for (int r = 0; r < N; r++) begin
            if (mask[r] && $urandom_range(99) < pv) begin
                req_valid_i[r] = 1'b1;
                req_data_i[r]  = pdata[r];
                req_last_i[r]  = (left[r] == 1);
            end else begin
                req_valid_i[r] = 1'b0;
                req_data_i[r]  = W'($urandom);
                req_last_i[r]  = 1'($urandom);
            end
        end
        fifo_full_i = ($urandom_range(99) < pf);
    endtask

    task automatic push_expect();
        cyc_t e;
        e = '0;
        if (m_own >= 0) begin
            e.gnt[m_own] = 1'b1;
            e.busy       = 1'b1;
            e.rdy[m_own] = !fifo_full_i;
            e.wen        = req_valid_i[m_own] && !fifo_full_i;
            if (e.wen) wr_q.push_back({2'(m_own), req_data_i[m_own]});
        end
        exp_q.push_back(e);
    endtask

    task automatic step(input int pv, input int pf, input logic [N-1:0] mask);
        @(posedge clk_wr);
        #1;
        if (arst_wr) arst_wr = 1'b0;
        if (!skip_adv) model_advance();
        skip_adv = 1'b0;
        drive(pv, pf, mask);
        push_expect();
    endtask

    // Monitor: per-cycle status every cycle, FIFO data whenever a write shows
    initial begin
        cyc_t e;
        logic [9:0] w;
        forever begin
            @(negedge clk_wr);
            if (fifo_wr_en_o && fifo_full_i) chk("wr_en_while_full", 1, 0);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("grant", 32'(grant_o), 32'(e.gnt));
                chk("ready", 32'(req_ready_o), 32'(e.rdy));
                chk("busy_wen", 32'({busy_o, fifo_wr_en_o}), 32'({e.busy, e.wen}));
            end
            if (fifo_wr_en_o) begin
                if (wr_q.size() == 0) begin
                    chk("unexpected_write", 32'(fifo_wr_data_o), 32'h0);
                end else begin
                    w = wr_q.pop_front();
                    chk("wr_data", 32'(fifo_wr_data_o), 32'(w));
                end
            end
        end
    end

    initial begin
        int guard;
        for (int r = 0; r < N; r++) begin
            left[r]  = 3;
            pdata[r] = W'($urandom);
        end
        arst_wr     = 1'b1;
        req_valid_i = '1;
        req_data_i  = '1;
        req_last_i  = '0;
        fifo_full_i = 1'b0;
        repeat (2) @(posedge clk_wr);
        #1;
        chk("rst_ready", 32'(req_ready_o), 0);
        chk("rst_grant", 32'(grant_o), 0);
        chk("rst_busy_wen", 32'({busy_o, fifo_wr_en_o}), 0);
        chk("rst_wdata", 32'(fifo_wr_data_o), 0);

        // Single requester 2, 3-beat packet
        lmin = 3; lmax = 3;
        repeat (8) step(100, 0, 4'b0100);
        // All requesters, last on every beat
        lmin = 1; lmax = 1;
        for (int r = 0; r < N; r++) left[r] = 1;
        repeat (16) step(100, 0, 4'b1111);
        // Req 1 streams long packets, others sporadic single beats
        left[1] = 10;
        repeat (40) step(100, 0, 4'b0010);
        repeat (30) step(100, 0, 4'b1111);
        // Directed 5-cycle stall mid-burst
        lmin = 6; lmax = 6;
        guard = 0;
        while ((m_own < 0 || m_beats != 1) && guard < 40) begin
            step(100, 0, 4'b1111);
            guard++;
        end
        repeat (5) step(100, 100, 4'b1111);
        repeat (10) step(100, 0, 4'b1111);
        // Random traffic with gaps, stalls and abandons
        lmin = 1; lmax = 6;
        repeat (400) step(70, 25, 4'b1111);
        // Reset in the middle of a transferring burst
        lmin = 8; lmax = 8;
        guard = 0;
        while ((m_own < 0 || m_beats > 1) && guard < 40) begin
            step(100, 0, 4'b1111);
            guard++;
        end
        @(posedge clk_wr);
        #1;
        model_advance();
        drive(100, 0, 4'b1111);
        #1;
        chk("pre_rst_wen", 32'(fifo_wr_en_o), 32'(m_own >= 0));
        arst_wr = 1'b1;
        #1;
        chk("midrst_ready", 32'(req_ready_o), 0);
        chk("midrst_grant", 32'(grant_o), 0);
        chk("midrst_busy_wen", 32'({busy_o, fifo_wr_en_o}), 0);
        chk("midrst_wdata", 32'(fifo_wr_data_o), 0);
        m_own = -1; m_ptr = 0; m_beats = 0;
        skip_adv = 1'b1;
        push_expect();
        repeat (6) step(100, 0, 4'b1111);
        lmin = 1; lmax = 6;
        repeat (150) step(60, 30, 4'b1111);
        // Drain and make sure every expected write was seen
        repeat (4) step(0, 0, 4'b1111);
        @(negedge clk_wr);
        #1;
        chk("wr_queue_drained", 32'(wr_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
